// File: rtl/vfpu_pkg.sv
// -----------------------------------------------------------------------------
// vfpu_pkg
// Shared definitions for the vector FMA issue/writeback controller:
//   - vfpu opcode encodings and the broadcast funct code
//   - rounding-mode default
//   - issue controller FSM state encoding
// -----------------------------------------------------------------------------
package vfpu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_FMA = 5'b00011;
    localparam logic [4:0] OP_MIN = 5'b00100;
    localparam logic [4:0] OP_MAX = 5'b00101;

    // Opcode presented to the vfpu out of reset (a harmless multiply).
    localparam logic [4:0] OP_RESET = OP_MUL;

    localparam logic [2:0] FUNCT_DEFAULT = 3'b000;
    // Broadcast lane 0 of operand a across all lanes.
    localparam logic [2:0] FUNCT_BCAST   = 3'b101;

    localparam logic [2:0] RND_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } issue_state_e;

endpackage : vfpu_pkg

// File: rtl/vfpu_tag_pipe.sv
// -----------------------------------------------------------------------------
// vfpu_tag_pipe
// LATENCY-deep shadow of the vfpu pipeline carrying {valid, tag} per stage.
// Advances only when en=1 so it stays aligned with the clock-gated vfpu.
// clr drops every valid bit (stale datapath contents become don't-care);
// rst additionally zeroes the tags so wb_tag reads 0 out of reset.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            advance enable (mirrors vfpu_en)
//   clr           synchronous clear of all valid bits (flush)
//   in_v, in_tag  stage-0 input: issue fire and its destination tag
//   out_v, out_tag last stage: result valid and destination tag
// -----------------------------------------------------------------------------
module vfpu_tag_pipe #(
    parameter int LATENCY   = 3,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 in_v,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_v,
    output logic [TAG_WIDTH-1:0] out_tag
);

    logic [LATENCY-1:0]                v_r;
    logic [LATENCY-1:0][TAG_WIDTH-1:0] tag_r;

    // Shadow shift register: reset, flush-clear, or enabled advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r   <= {LATENCY{1'b0}};
            tag_r <= {(LATENCY*TAG_WIDTH){1'b0}};
        end else if (clr) begin
            v_r <= {LATENCY{1'b0}};
        end else if (en) begin
            v_r[0]   <= in_v;
            tag_r[0] <= in_tag;
            for (int k = 1; k < LATENCY; k++) begin
                v_r[k]   <= v_r[k-1];
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    assign out_v   = v_r[LATENCY-1];
    assign out_tag = tag_r[LATENCY-1];

endmodule : vfpu_tag_pipe

// File: rtl/vfpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// vfpu_issue_ctrl
// Issue/writeback controller between the vector decoder and the vfpu.
// One op per cycle on in_valid/in_ready; results are offered on
// wb_valid/wb_ready. Writeback back-pressure freezes the entire vfpu
// (vfpu_en=0) together with the shadow tag pipeline.
//
// Optional build macro: VFPU_ISSUE_CTRL_PERF_EN adds saturating counters
// perf_issued / perf_stall / perf_idle (cleared by rst only).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         issue handshake
//   in_opcode/in_funct/in_tag op fields and destination tag
//   flush                     discard all in-flight ops
//   cfg_rnd_we/cfg_rnd        rounding-mode write (ignored while busy)
//   vfpu_en                   vfpu clock-gate enable
//   vfpu_opcode/funct/rnd     vfpu control fields
//   wb_valid/wb_ready/wb_tag  writeback handshake and tag
//   busy                      at least one op in flight
// -----------------------------------------------------------------------------
module vfpu_issue_ctrl
    import vfpu_pkg::*;
#(
    parameter int LATENCY   = 3,
    parameter int TAG_WIDTH = 5
`ifdef VFPU_ISSUE_CTRL_PERF_EN
    ,
    parameter int CNT_WIDTH = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_opcode,
    input  logic [2:0]           in_funct,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 flush,
    input  logic                 cfg_rnd_we,
    input  logic [2:0]           cfg_rnd,
    output logic                 vfpu_en,
    output logic [4:0]           vfpu_opcode,
    output logic [2:0]           vfpu_funct,
    output logic [2:0]           vfpu_rnd,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic                 busy
`ifdef VFPU_ISSUE_CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_issued,
    output logic [CNT_WIDTH-1:0] perf_stall,
    output logic [CNT_WIDTH-1:0] perf_idle
`endif
);

    localparam int CW = $clog2(LATENCY + 1);

    logic          stall_s;
    logic          fire_s;
    logic          consume_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [4:0]    op_hold_r;
    logic [2:0]    funct_hold_r;
    logic [2:0]    rnd_r;
    issue_state_e  state_r;
    issue_state_e  state_nxt_s;

    assign stall_s   = wb_valid & ~wb_ready;
    assign vfpu_en   = ~stall_s;
    assign in_ready  = ~stall_s & ~flush;
    assign fire_s    = in_valid & in_ready;
    assign consume_s = wb_valid & wb_ready;
    assign busy      = (count_r != {CW{1'b0}});
    assign vfpu_rnd  = rnd_r;

    // Fields pass straight through on fire; otherwise replay the last issued
    // values so the vfpu inputs never toggle without a real issue.
    assign vfpu_opcode = fire_s ? in_opcode : op_hold_r;
    assign vfpu_funct  = fire_s ? in_funct  : funct_hold_r;

    vfpu_tag_pipe #(
        .LATENCY   (LATENCY),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .en      (vfpu_en),
        .clr     (flush),
        .in_v    (fire_s),
        .in_tag  (in_tag),
        .out_v   (wb_valid),
        .out_tag (wb_tag)
    );

    // In-flight counter next value: flush wins, fire+consume cancel out.
    always_comb begin
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            case ({fire_s, consume_s})
                2'b10:   count_nxt_s = count_r + CW'(1);
                2'b01:   count_nxt_s = count_r - CW'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fire_s) begin
                        state_nxt_s = ACTIVE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ACTIVE: begin
                    if (stall_s) begin
                        state_nxt_s = STALL;
                    end else if ((count_nxt_s == {CW{1'b0}}) && !fire_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = ACTIVE;
                    end
                end
                STALL: begin
                    if (wb_ready) begin
                        state_nxt_s = ACTIVE;
                    end else begin
                        state_nxt_s = STALL;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, counter, held issue fields and rounding-mode register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            count_r      <= {CW{1'b0}};
            op_hold_r    <= OP_RESET;
            funct_hold_r <= FUNCT_DEFAULT;
            rnd_r        <= RND_DEFAULT;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            if (fire_s) begin
                op_hold_r    <= in_opcode;
                funct_hold_r <= in_funct;
            end
            // Rounding mode only changes with nothing in flight.
            if (cfg_rnd_we && !busy) begin
                rnd_r <= cfg_rnd;
            end
        end
    end

`ifdef VFPU_ISSUE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] perf_issued_r;
    logic [CNT_WIDTH-1:0] perf_stall_r;
    logic [CNT_WIDTH-1:0] perf_idle_r;

    // Saturating performance counters; unaffected by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_r <= {CNT_WIDTH{1'b0}};
            perf_stall_r  <= {CNT_WIDTH{1'b0}};
            perf_idle_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            if (fire_s && (perf_issued_r != {CNT_WIDTH{1'b1}})) begin
                perf_issued_r <= perf_issued_r + CNT_WIDTH'(1);
            end
            if (stall_s && (perf_stall_r != {CNT_WIDTH{1'b1}})) begin
                perf_stall_r <= perf_stall_r + CNT_WIDTH'(1);
            end
            if ((state_r == IDLE) && (perf_idle_r != {CNT_WIDTH{1'b1}})) begin
                perf_idle_r <= perf_idle_r + CNT_WIDTH'(1);
            end
        end
    end

    assign perf_issued = perf_issued_r;
    assign perf_stall  = perf_stall_r;
    assign perf_idle   = perf_idle_r;
`endif

endmodule : vfpu_issue_ctrl
